// File: rtl/fpdiv_pkg.sv
// Shared types and constants for the f32 divide/sqrt issue sequencer.
// f32_div_special classifies divide operands that can be answered without iterating.
package fpdiv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [1:0]  OP_DIV      = 2'b00;
  localparam logic [1:0]  OP_SQRT     = 2'b01;
  localparam logic [31:0] F32_QNAN    = 32'h7FC0_0000;
  localparam logic [7:0]  F32_INF_EXP = 8'hFF;

  typedef struct packed {
    logic        rm;
    logic [1:0]  op;
    logic [31:0] n;
    logic [31:0] d;
  } req_t;

  // Bit 32 flags a special operand pair; bits 31:0 hold the ready-made result.
  function automatic logic [32:0] f32_div_special(input logic [31:0] n, input logic [31:0] d);
    logic n_nan, n_inf, n_zero, d_nan, d_inf, d_zero, sign;
    n_nan  = (n[30:23] == F32_INF_EXP) && (n[22:0] != 23'd0);
    n_inf  = (n[30:23] == F32_INF_EXP) && (n[22:0] == 23'd0);
    n_zero = (n[30:0] == 31'd0);
    d_nan  = (d[30:23] == F32_INF_EXP) && (d[22:0] != 23'd0);
    d_inf  = (d[30:23] == F32_INF_EXP) && (d[22:0] == 23'd0);
    d_zero = (d[30:0] == 31'd0);
    sign   = n[31] ^ d[31];
    if (n_nan || d_nan || (n_zero && d_zero) || (n_inf && d_inf))
      f32_div_special = {1'b1, F32_QNAN};
    else if (d_zero || n_inf)
      f32_div_special = {1'b1, sign, F32_INF_EXP, 23'd0};
    else if (n_zero || d_inf)
      f32_div_special = {1'b1, sign, 31'd0};
    else
      f32_div_special = 33'd0;
  endfunction

endpackage

// File: rtl/fpdiv_sequencer_if.sv
// Request, response and divider-side signals of the f32 divide sequencer.
interface fpdiv_sequencer_if;
  import fpdiv_pkg::*;

  // A transfer happens on the rising edge where valid && ready; valid never waits on ready.
  logic        req_valid;
  logic        req_ready;
  logic        req_rm;
  logic [1:0]  req_op;
  logic [31:0] req_n;
  logic [31:0] req_d;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_result;
  logic        busy;
  logic        div_reset;
  logic        div_rm;
  logic [1:0]  div_op;
  logic [31:0] div_n;
  logic [31:0] div_d;
  logic [31:0] div_result;
  state_t      dbg_state;

  modport slave (
    input  req_valid, req_rm, req_op, req_n, req_d, resp_ready, div_result,
    output req_ready, resp_valid, resp_result, busy,
           div_reset, div_rm, div_op, div_n, div_d, dbg_state
  );

  modport master (
    output req_valid, req_rm, req_op, req_n, req_d, resp_ready, div_result,
    input  req_ready, resp_valid, resp_result, busy,
           div_reset, div_rm, div_op, div_n, div_d, dbg_state
  );
endinterface

// File: rtl/fpdiv_req_fifo.sv
// Synchronous request FIFO with wrap-around pointers; DEPTH must be a power of two.
module fpdiv_req_fifo
  import fpdiv_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_push,
  input  req_t                     i_data,
  input  logic                     i_pop,
  output req_t                     o_data,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);
  localparam int AW = $clog2(DEPTH);

  req_t           r_mem [DEPTH];
  logic [AW-1:0]  r_wr_ptr;
  logic [AW-1:0]  r_rd_ptr;
  logic [AW:0]    r_count;
  logic           w_do_push;
  logic           w_do_pop;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_data    = r_mem[r_rd_ptr];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/fpdiv_sequencer.sv
// Issue/completion controller in front of an iterative f32 divide/sqrt unit.
// Define FPDIV_SPECIAL_BYPASS_EN to answer special divide operands without the divider.
module fpdiv_sequencer
  import fpdiv_pkg::*;
#(
  parameter int LATENCY = 12,
  parameter int DEPTH   = 2
) (
  input  logic               clk,
  input  logic               reset,
  fpdiv_sequencer_if.slave   bus
);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int AW = $clog2(DEPTH);

  state_t         r_state;
  state_t         w_next_state;
  logic [CW-1:0]  r_cnt;
  req_t           r_op;
  logic [31:0]    r_result;
  req_t           w_req;
  req_t           w_head;
  logic           w_req_ready;
  logic           w_push;
  logic           w_pop;
  logic           w_full;
  logic           w_empty;
  logic [AW:0]    w_count;

  assign w_req       = {bus.req_rm, bus.req_op, bus.req_n, bus.req_d};
  assign w_req_ready = !w_full && !reset;
  assign w_push      = bus.req_valid && w_req_ready;

  fpdiv_req_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_data  (w_req),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

`ifdef FPDIV_SPECIAL_BYPASS_EN
  logic [32:0] w_special;
  logic        w_special_hit;
  assign w_special     = f32_div_special(w_head.n, w_head.d);
  assign w_special_hit = (w_head.op == OP_DIV) && w_special[32];
`endif

  always_comb begin
    w_next_state = r_state;
    w_pop        = 1'b0;
    case (r_state)
      ST_IDLE: if (!w_empty) begin
        w_pop        = 1'b1;
        w_next_state = ST_LOAD;
      end
      ST_LOAD: w_next_state = ST_RUN;
      ST_RUN:  if (r_cnt == '0) w_next_state = ST_DONE;
      ST_DONE: if (bus.resp_ready) begin
        if (!w_empty) begin
          w_pop        = 1'b1;
          w_next_state = ST_LOAD;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
`ifdef FPDIV_SPECIAL_BYPASS_EN
    if (w_pop && w_special_hit) w_next_state = ST_DONE;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_op     <= '0;
      r_result <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_pop) r_op <= w_head;
      if (r_state == ST_LOAD)
        r_cnt <= CW'(LATENCY - 1);
      else if (r_state == ST_RUN && r_cnt != '0)
        r_cnt <= r_cnt - CW'(1);
      if (r_state == ST_RUN && r_cnt == '0) r_result <= bus.div_result;
`ifdef FPDIV_SPECIAL_BYPASS_EN
      if (w_pop && w_special_hit) r_result <= w_special[31:0];
`endif
    end
  end

  // Divider is held in reset everywhere except RUN, so operands settle during LOAD.
  assign bus.req_ready   = w_req_ready;
  assign bus.resp_valid  = (r_state == ST_DONE);
  assign bus.resp_result = r_result;
  assign bus.busy        = (r_state != ST_IDLE) || (w_count != '0);
  assign bus.div_reset   = (r_state != ST_RUN);
  assign bus.div_rm      = r_op.rm;
  assign bus.div_op      = r_op.op;
  assign bus.div_n       = r_op.n;
  assign bus.div_d       = r_op.d;
  assign bus.dbg_state   = r_state;
endmodule

// File: tb/tb_fpdiv_sequencer.sv
// Self-checking bench for fpdiv_sequencer with a behavioural divider stand-in.
module tb_fpdiv_sequencer;
  import fpdiv_pkg::*;

  localparam int LATENCY = 12;
  localparam int DEPTH   = 2;
  localparam int TIMEOUT = 200;
`ifdef FPDIV_SPECIAL_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   cyc   = 0;
  int   dcnt  = 0;
  int   n_vec = 0;
  int   n_err = 0;
  logic [31:0] exp_q[$];

  fpdiv_sequencer_if bus();

  fpdiv_sequencer #(.LATENCY(LATENCY), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- clock / cycle count / divider model ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    if (bus.div_reset) dcnt <= 0;
    else               dcnt <= dcnt + 1;
  end
  // Result is only meaningful on the last cycle of the run; anything earlier is poison.
  assign bus.div_result = (!bus.div_reset && dcnt == LATENCY - 1) ?
                          div_fn(bus.div_rm, bus.div_op, bus.div_n, bus.div_d) : 32'hBAD0_BAD0;

  function automatic logic [31:0] div_fn(input logic rm, input logic [1:0] op,
                                         input logic [31:0] n, input logic [31:0] d);
    logic [47:0] num, den, q;
    logic [22:0] m;
    logic [31:0] r;
    int e;
    if (op == OP_DIV) begin
      num = {1'b1, n[22:0], 24'd0};
      den = {24'd0, 1'b1, d[22:0]};
      q   = num / den;
      e   = int'(n[30:23]) - int'(d[30:23]) + 127;
      if (q[24]) m = q[23:1];
      else begin
        m = q[22:0];
        e = e - 1;
      end
      r = {n[31] ^ d[31], e[7:0], m} ^ {31'd0, rm};
    end else if (op == OP_SQRT) begin
      r = {1'b0, n[30:0]} ^ d ^ {31'd0, rm};
    end else begin
      r = n + d + {31'd0, rm};
    end
    return r;
  endfunction

  // ---------------- reference model ----------------
  // 0 zero, 1 finite nonzero (incl. subnormal), 2 infinity, 3 NaN
  function automatic int kind(input logic [31:0] x);
    if (x[30:23] == 8'hFF) return (x[22:0] == 23'd0) ? 2 : 3;
    if (x[30:0] == 31'd0)  return 0;
    return 1;
  endfunction

  function automatic bit takes_bypass(input req_t r);
    return BYPASS && (r.op == OP_DIV) && (kind(r.n) != 1 || kind(r.d) != 1);
  endfunction

  function automatic logic [31:0] ref_result(input req_t r);
    int kn, kd;
    logic s;
    kn = kind(r.n);
    kd = kind(r.d);
    s  = r.n[31] ^ r.d[31];
    if (!takes_bypass(r)) return div_fn(r.rm, r.op, r.n, r.d);
    if (kn == 3 || kd == 3 || (kn == 0 && kd == 0) || (kn == 2 && kd == 2)) return 32'h7FC0_0000;
    if (kd == 0 || kn == 2) return {s, 31'h7F80_0000};
    return {s, 31'd0};
  endfunction

  function automatic int ref_latency(input req_t r);
    return takes_bypass(r) ? 2 : LATENCY + 3;
  endfunction

  function automatic req_t mk_req(input logic rm, input logic [1:0] op,
                                  input logic [31:0] n, input logic [31:0] d);
    req_t r;
    r.rm = rm; r.op = op; r.n = n; r.d = d;
    return r;
  endfunction

  function automatic logic [31:0] rand_normal();
    logic [7:0] e;
    e = 8'($urandom_range(100, 150));
    return {1'($urandom_range(0, 1)), e, 23'($urandom)};
  endfunction

  // ---------------- driver tasks (enter and leave just after a rising edge) ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_push(input req_t r, output int acc, output bit ok);
    ok  = 1'b0;
    acc = 0;
    bus.req_valid = 1'b1;
    bus.req_rm    = r.rm;
    bus.req_op    = r.op;
    bus.req_n     = r.n;
    bus.req_d     = r.d;
    for (int i = 0; i < TIMEOUT; i++) begin
      @(negedge clk);
      if (bus.req_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    n_vec++;
    if (ok) begin
      acc = cyc;
      exp_q.push_back(ref_result(r));
    end else begin
      n_err++;
      $display("FAIL push_timeout: req_ready stayed %b, expected 1 within %0d cycles", bus.req_ready, TIMEOUT);
    end
    step();
    bus.req_valid = 1'b0;
  endtask

  // Returns on the falling edge of the first cycle with resp_valid high.
  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < TIMEOUT; i++) begin
      @(negedge clk);
      if (bus.resp_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL resp_timeout: resp_valid stayed %b, expected 1 within %0d cycles", bus.resp_valid, TIMEOUT);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if (bus.req_ready !== 1'b0) begin
      n_err++;
      $display("FAIL reset_ready_low: req_ready=%b expected 0", bus.req_ready);
    end
    step();
    reset = 1'b0;
    @(negedge clk);
    n_vec += 5;
    if (bus.dbg_state !== ST_IDLE) begin
      n_err++;
      $display("FAIL reset_state: state=%0d expected %0d", bus.dbg_state, ST_IDLE);
    end
    if (bus.req_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_ready_high: req_ready=%b expected 1", bus.req_ready);
    end
    if ({bus.resp_valid, bus.busy, bus.div_reset, bus.div_rm, bus.div_op} !== 6'b001000) begin
      n_err++;
      $display("FAIL reset_flags: valid/busy/div_reset/rm/op=%b expected 001000",
               {bus.resp_valid, bus.busy, bus.div_reset, bus.div_rm, bus.div_op});
    end
    if (bus.resp_result !== 32'd0) begin
      n_err++;
      $display("FAIL reset_result: resp_result=%h expected 00000000", bus.resp_result);
    end
    if ({bus.div_n, bus.div_d} !== 64'd0) begin
      n_err++;
      $display("FAIL reset_operands: div_n=%h div_d=%h expected 0", bus.div_n, bus.div_d);
    end
    step();
  endtask

  task automatic test_single_div();
    int acc;
    bit ok, vok;
    logic [31:0] e;
    exp_q.delete();
    bus.resp_ready = 1'b1;
    drive_push(mk_req(1'b0, OP_DIV, 32'h40C0_0000, 32'h4000_0000), acc, ok);
    wait_valid(vok);
    if (vok) begin
      e = exp_q.pop_front();
      n_vec += 2;
      if (cyc - acc != 15) begin
        n_err++;
        $display("FAIL single_latency: latency=%0d expected 15", cyc - acc);
      end
      if (bus.resp_result !== 32'h4040_0000 || e !== 32'h4040_0000) begin
        n_err++;
        $display("FAIL single_result: resp_result=%h expected 40400000", bus.resp_result);
      end
    end
    step();
    @(negedge clk);
    n_vec++;
    if (bus.resp_valid !== 1'b0 || bus.busy !== 1'b0 || bus.dbg_state !== ST_IDLE) begin
      n_err++;
      $display("FAIL single_idle: valid=%b busy=%b state=%0d expected 0 0 %0d",
               bus.resp_valid, bus.busy, bus.dbg_state, ST_IDLE);
    end
    step();
  endtask

  task automatic test_back_to_back();
    int acc[3];
    int t_done[3];
    bit ok, vok;
    logic [31:0] e;
    exp_q.delete();
    bus.resp_ready = 1'b1;
    for (int k = 0; k < 3; k++)
      drive_push(mk_req(1'($urandom_range(0, 1)), OP_DIV, rand_normal(), rand_normal()), acc[k], ok);
    @(negedge clk);
    n_vec++;
    if (bus.req_ready !== 1'b0 || bus.dbg_state !== ST_RUN) begin
      n_err++;
      $display("FAIL b2b_full: req_ready=%b state=%0d expected 0 %0d", bus.req_ready, bus.dbg_state, ST_RUN);
    end
    for (int k = 0; k < 3; k++) begin
      wait_valid(vok);
      if (vok) begin
        t_done[k] = cyc;
        e = exp_q.pop_front();
        n_vec += 2;
        if (bus.resp_result !== e) begin
          n_err++;
          $display("FAIL b2b_result%0d: resp_result=%h expected %h", k, bus.resp_result, e);
        end
        if (k == 0 && t_done[0] - acc[0] != 15) begin
          n_err++;
          $display("FAIL b2b_latency: latency=%0d expected 15", t_done[0] - acc[0]);
        end else if (k > 0 && t_done[k] - t_done[k-1] != LATENCY + 2) begin
          n_err++;
          $display("FAIL b2b_spacing%0d: spacing=%0d expected %0d", k, t_done[k] - t_done[k-1], LATENCY + 2);
        end
      end
      step();
    end
  endtask

  task automatic test_backpressure();
    req_t r[3];
    int acc;
    bit ok, vok;
    logic [31:0] e;
    exp_q.delete();
    bus.resp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      r[k] = mk_req(1'($urandom_range(0, 1)), OP_DIV, rand_normal(), rand_normal());
      drive_push(r[k], acc, ok);
    end
    wait_valid(vok);
    e = exp_q.pop_front();
    n_vec++;
    if (bus.resp_result !== e) begin
      n_err++;
      $display("FAIL bp_result: resp_result=%h expected %h", bus.resp_result, e);
    end
    for (int i = 0; i < 20; i++) begin
      step();
      @(negedge clk);
      n_vec += 3;
      if ({bus.resp_valid, bus.div_reset, bus.req_ready} !== 3'b110) begin
        n_err++;
        $display("FAIL bp_hold_flags%0d: valid/div_reset/req_ready=%b expected 110", i,
                 {bus.resp_valid, bus.div_reset, bus.req_ready});
      end
      if (bus.resp_result !== e) begin
        n_err++;
        $display("FAIL bp_hold_result%0d: resp_result=%h expected %h", i, bus.resp_result, e);
      end
      if (bus.dbg_state !== ST_DONE || bus.div_n !== r[0].n) begin
        n_err++;
        $display("FAIL bp_hold_state%0d: state=%0d div_n=%h expected %0d %h", i,
                 bus.dbg_state, bus.div_n, ST_DONE, r[0].n);
      end
    end
    step();
    bus.resp_ready = 1'b1;
    @(negedge clk);
    step();
    @(negedge clk);
    n_vec++;
    if (bus.dbg_state !== ST_LOAD || bus.div_n !== r[1].n || bus.div_d !== r[1].d) begin
      n_err++;
      $display("FAIL bp_release: state=%0d div_n=%h expected %0d %h", bus.dbg_state, bus.div_n, ST_LOAD, r[1].n);
    end
    step();
    for (int k = 0; k < 2; k++) begin
      wait_valid(vok);
      if (vok) begin
        e = exp_q.pop_front();
        n_vec++;
        if (bus.resp_result !== e) begin
          n_err++;
          $display("FAIL bp_drain%0d: resp_result=%h expected %h", k, bus.resp_result, e);
        end
      end
      step();
    end
  endtask

  task automatic test_special();
    logic [31:0] tn [6];
    logic [31:0] td [6];
    logic [1:0]  to [6];
    req_t r;
    int acc;
    bit ok, vok;
    logic [31:0] e;
    tn = '{32'h3F80_0000, 32'h7FC0_0001, 32'h3F80_0000, 32'h8000_0000, 32'h7F80_0000, 32'hC000_0000};
    td = '{32'h0000_0000, 32'h3F80_0000, 32'h0000_0000, 32'h4000_0000, 32'hFF80_0000, 32'h7F80_0000};
    to = '{OP_DIV, OP_DIV, OP_SQRT, OP_DIV, OP_DIV, OP_DIV};
    exp_q.delete();
    bus.resp_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      r = mk_req(1'b0, to[k], tn[k], td[k]);
      drive_push(r, acc, ok);
      wait_valid(vok);
      if (vok) begin
        e = exp_q.pop_front();
        n_vec += 2;
        if (cyc - acc != ref_latency(r)) begin
          n_err++;
          $display("FAIL special_latency%0d: latency=%0d expected %0d", k, cyc - acc, ref_latency(r));
        end
        if (bus.resp_result !== e) begin
          n_err++;
          $display("FAIL special_result%0d: resp_result=%h expected %h", k, bus.resp_result, e);
        end
      end
      step();
    end
  endtask

  task automatic test_random();
    localparam int N = 30;
    exp_q.delete();
    fork
      begin
        req_t p_r;
        int   p_acc, p_gap;
        bit   p_ok;
        logic [1:0] p_op;
        for (int i = 0; i < N; i++) begin
          p_gap = $urandom_range(0, 2);
          for (int g = 0; g < p_gap; g++) step();
          p_op = ($urandom_range(0, 9) < 6) ? OP_DIV :
                 ($urandom_range(0, 1) == 0) ? OP_SQRT : 2'($urandom_range(2, 3));
          p_r = mk_req(1'($urandom_range(0, 1)), p_op, rand_normal(),
                       ($urandom_range(0, 7) == 0) ? 32'd0 : rand_normal());
          drive_push(p_r, p_acc, p_ok);
        end
      end
      begin
        int c_got;
        logic [31:0] c_e;
        c_got = 0;
        for (int c = 0; c < N * 40 && c_got < N; c++) begin
          bus.resp_ready = ($urandom_range(0, 3) != 0);
          @(negedge clk);
          if (bus.resp_valid === 1'b1 && bus.resp_ready === 1'b1) begin
            n_vec++;
            if (exp_q.size() == 0) begin
              n_err++;
              $display("FAIL rand_extra: resp_result=%h expected no response", bus.resp_result);
            end else begin
              c_e = exp_q.pop_front();
              if (bus.resp_result !== c_e) begin
                n_err++;
                $display("FAIL rand_result%0d: resp_result=%h expected %h", c_got, bus.resp_result, c_e);
              end
            end
            c_got++;
          end
          step();
        end
        n_vec++;
        if (c_got != N) begin
          n_err++;
          $display("FAIL rand_count: responses=%0d expected %0d", c_got, N);
        end
      end
    join
    bus.resp_ready = 1'b1;
    repeat (3) step();
    @(negedge clk);
    n_vec++;
    if (bus.busy !== 1'b0 || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL rand_drain: busy=%b pending=%0d expected 0 0", bus.busy, exp_q.size());
    end
    step();
  endtask

  task automatic test_reset_mid();
    int acc;
    bit ok;
    exp_q.delete();
    bus.resp_ready = 1'b1;
    for (int k = 0; k < 3; k++)
      drive_push(mk_req(1'b0, OP_DIV, rand_normal(), rand_normal()), acc, ok);
    @(negedge clk);
    n_vec++;
    if (bus.dbg_state !== ST_RUN) begin
      n_err++;
      $display("FAIL rst_mid_run: state=%0d expected %0d", bus.dbg_state, ST_RUN);
    end
    repeat (6) step();
    reset = 1'b1;
    @(negedge clk);
    n_vec++;
    if (bus.req_ready !== 1'b0) begin
      n_err++;
      $display("FAIL rst_mid_ready: req_ready=%b expected 0", bus.req_ready);
    end
    step();
    reset = 1'b0;
    exp_q.delete();
    @(negedge clk);
    n_vec += 2;
    if (bus.dbg_state !== ST_IDLE || bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL rst_mid_idle: state=%0d busy=%b expected %0d 0", bus.dbg_state, bus.busy, ST_IDLE);
    end
    if ({bus.resp_valid, bus.div_reset, bus.req_ready} !== 3'b011) begin
      n_err++;
      $display("FAIL rst_mid_flags: valid/div_reset/req_ready=%b expected 011",
               {bus.resp_valid, bus.div_reset, bus.req_ready});
    end
    for (int i = 0; i < 40; i++) begin
      step();
      @(negedge clk);
      n_vec++;
      if (bus.resp_valid !== 1'b0 || bus.busy !== 1'b0) begin
        n_err++;
        $display("FAIL rst_mid_quiet%0d: valid=%b busy=%b expected 0 0", i, bus.resp_valid, bus.busy);
      end
    end
    step();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    bus.req_valid  = 1'b0;
    bus.req_rm     = 1'b0;
    bus.req_op     = 2'b00;
    bus.req_n      = 32'd0;
    bus.req_d      = 32'd0;
    bus.resp_ready = 1'b0;
    test_reset();
    test_single_div();
    test_back_to_back();
    test_backpressure();
    test_special();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
